aes_uart_sequencer: RTL and testbench

AES_UART_SEQUENCER -- requirements
Module: aes_uart_sequencer

---
 rtl/aes_seq_pkg.sv | 47 ++++
 rtl/aes_seq_decode.sv | 39 +++
 rtl/aes_uart_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_aes_uart_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared constants, state/opcode enums and frame helpers for the AES UART sequencer.
package aes_seq_pkg;

    localparam int FRAME_W   = 144;
    localparam int PAYLOAD_W = 128;

    localparam logic [7:0] OP_CONST    = 8'h41;  // "A"
    localparam logic [7:0] OP_SET_KEY  = 8'h43;  // "C"
    localparam logic [7:0] OP_SET_TEXT = 8'h44;  // "D"
    localparam logic [7:0] OP_GET_KEY  = 8'h61;  // "a"
    localparam logic [7:0] OP_GET_TEXT = 8'h62;  // "b"
    localparam logic [7:0] OP_GET_RES  = 8'h40;  // "@"
    localparam logic [7:0] OP_ENCRYPT  = 8'h45;  // "E"

    localparam logic [7:0] ST_OK      = 8'h4B;   // "K"
    localparam logic [7:0] ST_BAD     = 8'h58;   // "X"
    localparam logic [7:0] ST_TIMEOUT = 8'h54;   // "T"

    localparam logic [PAYLOAD_W-1:0] CONST_PAYLOAD = 128'h30313233343536373839414243444546;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_AES_LD   = 3'd2,
        S_AES_WAIT = 3'd3,
        S_RESP     = 3'd4,
        S_TX_WAIT  = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        OPC_CONST    = 3'd0,
        OPC_SET_KEY  = 3'd1,
        OPC_SET_TEXT = 3'd2,
        OPC_GET_KEY  = 3'd3,
        OPC_GET_TEXT = 3'd4,
        OPC_GET_RES  = 3'd5,
        OPC_ENCRYPT  = 3'd6,
        OPC_BAD      = 3'd7
    } op_class_e;

    function automatic logic [FRAME_W-1:0] make_resp(input logic [7:0]           status,
                                                     input logic [PAYLOAD_W-1:0] payload,
                                                     input logic [7:0]           opcode);
        return {status, payload, opcode};
    endfunction

endpackage

// File: rtl/aes_seq_decode.sv
// Frame validation and opcode classification: a frame is only usable when its
// trailer byte repeats the opcode and the opcode is one the sequencer knows.
module aes_seq_decode
    import aes_seq_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_W / 8
) (
    input  logic [FRAME_BYTES*8-1:0] i_frame,
    output logic [7:0]               o_opcode,
    output logic [PAYLOAD_W-1:0]     o_payload,
    output op_class_e                o_class
);

    logic [7:0] w_trailer;

    assign o_opcode  = i_frame[7:0];
    assign o_payload = i_frame[PAYLOAD_W+7:8];
    assign w_trailer = i_frame[FRAME_BYTES*8-1 -: 8];

    // classify the opcode, collapsing trailer mismatches into the bad class
    always_comb begin
        o_class = OPC_BAD;
        if (w_trailer != o_opcode) begin
            o_class = OPC_BAD;
        end else begin
            case (o_opcode)
                OP_CONST:    o_class = OPC_CONST;
                OP_SET_KEY:  o_class = OPC_SET_KEY;
                OP_SET_TEXT: o_class = OPC_SET_TEXT;
                OP_GET_KEY:  o_class = OPC_GET_KEY;
                OP_GET_TEXT: o_class = OPC_GET_TEXT;
                OP_GET_RES:  o_class = OPC_GET_RES;
                OP_ENCRYPT:  o_class = OPC_ENCRYPT;
                default:     o_class = OPC_BAD;
            endcase
        end
    end

endmodule

// File: rtl/aes_uart_sequencer.sv
// Command sequencer between a UART frame interface and an AES core.
// Optional AES_SEQ_TIMEOUT_EN adds a watchdog on the cipher wait.
module aes_uart_sequencer
    import aes_seq_pkg::*;
#(
    parameter int FRAME_BYTES    = FRAME_W / 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FRAME_BYTES*8-1:0] rx_frame,
    input  logic                     rx_valid,
    output logic [FRAME_BYTES*8-1:0] tx_frame,
    output logic                     tx_send,
    input  logic                     tx_busy,
    output logic [PAYLOAD_W-1:0]     aes_key,
    output logic [PAYLOAD_W-1:0]     aes_text,
    output logic                     aes_ld,
    input  logic                     aes_done,
    input  logic [PAYLOAD_W-1:0]     aes_result,
    output logic                     busy,
    output logic [7:0]               drop_cnt
);

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [FRAME_BYTES*8-1:0] r_frame;
    logic [PAYLOAD_W-1:0]     r_aes_key;
    logic [PAYLOAD_W-1:0]     r_aes_text;
    logic [PAYLOAD_W-1:0]     r_result;
    logic [FRAME_BYTES*8-1:0] r_resp;
    logic [FRAME_BYTES*8-1:0] r_tx_frame;
    logic                     r_tx_send;
    logic                     r_aes_ld;
    logic                     r_busy;
    logic [7:0]               r_drop_cnt;
    logic                     r_seen_busy;
    logic                     r_txw_cnt;

    logic [7:0]               w_opcode;
    logic [PAYLOAD_W-1:0]     w_payload;
    op_class_e                w_class;
    logic                     w_drop;
    logic                     w_drop_inc;
    logic                     w_timeout;

    aes_seq_decode #(.FRAME_BYTES(FRAME_BYTES)) u_decode (
        .i_frame   (r_frame),
        .o_opcode  (w_opcode),
        .o_payload (w_payload),
        .o_class   (w_class)
    );

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    // count cycles spent waiting for the cipher; cleared whenever we leave the wait
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if (r_state == S_AES_WAIT) begin
            r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            r_to_cnt <= {TO_W{1'b0}};
        end
    end

    assign w_timeout = (r_state == S_AES_WAIT) && !aes_done &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    assign w_drop     = rx_valid && (r_state != S_IDLE);
    assign w_drop_inc = w_drop || ((r_state == S_DECODE) && (w_class == OPC_BAD)) || w_timeout;

    // next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) w_state_nxt = S_DECODE;
                else          w_state_nxt = S_IDLE;
            end
            S_DECODE: begin
                if (w_class == OPC_ENCRYPT) w_state_nxt = S_AES_LD;
                else                        w_state_nxt = S_RESP;
            end
            S_AES_LD: w_state_nxt = S_AES_WAIT;
            S_AES_WAIT: begin
                if (aes_done || w_timeout) w_state_nxt = S_RESP;
                else                       w_state_nxt = S_AES_WAIT;
            end
            S_RESP: begin
                if (!tx_busy) w_state_nxt = S_TX_WAIT;
                else          w_state_nxt = S_RESP;
            end
            S_TX_WAIT: begin
                // leave after a busy high->low handshake, or after two quiet cycles
                if (!tx_busy && (r_seen_busy || r_txw_cnt)) w_state_nxt = S_IDLE;
                else                                        w_state_nxt = S_TX_WAIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_frame     <= {(FRAME_BYTES*8){1'b0}};
            r_aes_key   <= {PAYLOAD_W{1'b0}};
            r_aes_text  <= {PAYLOAD_W{1'b0}};
            r_result    <= {PAYLOAD_W{1'b0}};
            r_resp      <= {(FRAME_BYTES*8){1'b0}};
            r_tx_frame  <= {(FRAME_BYTES*8){1'b0}};
            r_tx_send   <= 1'b0;
            r_aes_ld    <= 1'b0;
            r_busy      <= 1'b0;
            r_drop_cnt  <= 8'd0;
            r_seen_busy <= 1'b0;
            r_txw_cnt   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_aes_ld  <= (w_state_nxt == S_AES_LD);
            r_tx_send <= (r_state == S_RESP) && !tx_busy;
            if (w_drop_inc && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) r_frame <= rx_frame;
                end
                S_DECODE: begin
                    case (w_class)
                        OPC_CONST:    r_resp <= make_resp(ST_OK, CONST_PAYLOAD, w_opcode);
                        OPC_SET_KEY: begin
                            r_aes_key <= w_payload;
                            r_resp    <= make_resp(ST_OK, w_payload, w_opcode);
                        end
                        OPC_SET_TEXT: begin
                            r_aes_text <= w_payload;
                            r_resp     <= make_resp(ST_OK, w_payload, w_opcode);
                        end
                        OPC_GET_KEY:  r_resp <= make_resp(ST_OK, r_aes_key, w_opcode);
                        OPC_GET_TEXT: r_resp <= make_resp(ST_OK, r_aes_text, w_opcode);
                        OPC_GET_RES:  r_resp <= make_resp(ST_OK, r_result, w_opcode);
                        OPC_ENCRYPT:  r_resp <= r_resp;
                        default:      r_resp <= make_resp(ST_BAD, {PAYLOAD_W{1'b0}}, w_opcode);
                    endcase
                end
                S_AES_WAIT: begin
                    if (aes_done) begin
                        r_result <= aes_result;
                        r_resp   <= make_resp(ST_OK, aes_result, w_opcode);
                    end else if (w_timeout) begin
                        r_resp   <= make_resp(ST_TIMEOUT, {PAYLOAD_W{1'b0}}, w_opcode);
                    end
                end
                S_RESP: begin
                    r_tx_frame  <= r_resp;
                    r_seen_busy <= 1'b0;
                    r_txw_cnt   <= 1'b0;
                end
                S_TX_WAIT: begin
                    if (tx_busy) r_seen_busy <= 1'b1;
                    r_txw_cnt <= 1'b1;
                end
                default: begin
                    r_txw_cnt <= r_txw_cnt;
                end
            endcase
        end
    end

    assign tx_frame = r_tx_frame;
    assign tx_send  = r_tx_send;
    assign aes_key  = r_aes_key;
    assign aes_text = r_aes_text;
    assign aes_ld   = r_aes_ld;
    assign busy     = r_busy;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// Scoreboard bench for aes_uart_sequencer: directed frames push expected responses,
// a monitor pops and compares on every tx_send pulse.
module tb_aes_uart_sequencer;

    localparam logic [7:0] K = 8'h4B, X = 8'h58, T = 8'h54;
    localparam logic [7:0] OA = 8'h41, OC = 8'h43, OD = 8'h44, OE = 8'h45;
    localparam logic [7:0] OLA = 8'h61, OLB = 8'h62, OAT = 8'h40, OZ = 8'h5A;
    localparam logic [127:0] ASCII_HEX = 128'h30313233343536373839414243444546;
    localparam logic [127:0] PT  = 128'hf34481ec3cc627bacd5dc3fb08f273e6;
    localparam logic [127:0] CT  = 128'h0336763e966d92595a567cc9ce537f5e;
    localparam logic [127:0] KEY2 = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [143:0] rx_frame = 144'd0;
    logic         rx_valid = 1'b0;
    logic [143:0] tx_frame;
    logic         tx_send;
    logic         tx_busy = 1'b0;
    logic [127:0] aes_key;
    logic [127:0] aes_text;
    logic         aes_ld;
    logic         aes_done = 1'b0;
    logic [127:0] aes_result = 128'd0;
    logic         busy;
    logic [7:0]   drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_drop = 0;
    logic [143:0] exp_q[$];

    aes_uart_sequencer dut (
        .clk(clk), .rst(rst), .rx_frame(rx_frame), .rx_valid(rx_valid),
        .tx_frame(tx_frame), .tx_send(tx_send), .tx_busy(tx_busy),
        .aes_key(aes_key), .aes_text(aes_text), .aes_ld(aes_ld),
        .aes_done(aes_done), .aes_result(aes_result), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [127:0] pl, input logic [7:0] tr);
        @(negedge clk);
        rx_frame = {tr, pl, op};
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic push(input logic [7:0] st, input logic [127:0] pl, input logic [7:0] op);
        exp_q.push_back({st, pl, op});
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
        chk(name, {143'd0, ok}, 144'd1);
    endtask

    task automatic wait_ld(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1 if (aes_ld === 1'b1) seen = 1'b1;
        end
        chk(name, {143'd0, seen}, 144'd1);
    endtask

    // response monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_send === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_tx_send: got frame %h, expected no transmission", tx_frame);
                end else begin
                    chk("tx_frame", tx_frame, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        bit sent;

        #3;
        chk("rst_tx_frame", tx_frame, 144'd0);
        chk("rst_flags", {141'd0, tx_send, aes_ld, busy}, 144'd0);
        chk("rst_drop", {136'd0, drop_cnt}, 144'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // load zero key, check 3-cycle latency
        push(K, 128'd0, OC);
        send_frame(OC, 128'd0, OC);
        lat = 1;
        while (tx_send !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("latency", 144'(lat), 144'd3);
        wait_idle("idle_C");

        push(K, PT, OD);
        send_frame(OD, PT, OD);
        wait_idle("idle_D");
        chk("aes_text", {16'd0, aes_text}, {16'd0, PT});

        // encrypt with a dropped frame during the cipher wait
        send_frame(OE, 128'd0, OE);
        wait_ld("aes_ld_rise");
        chk("ld_key", {16'd0, aes_key}, 144'd0);
        chk("ld_text", {16'd0, aes_text}, {16'd0, PT});
        @(posedge clk);
        #1 chk("aes_ld_one_cycle", {143'd0, aes_ld}, 144'd0);
        send_frame(OA, 128'd0, OA);
        exp_drop++;
        push(K, CT, OE);
        @(negedge clk);
        aes_done = 1'b1;
        aes_result = CT;
        @(negedge clk);
        aes_done = 1'b0;
        wait_idle("idle_E");
        chk("drop_during_wait", {136'd0, drop_cnt}, 144'(exp_drop));

        push(K, CT, OAT);
        send_frame(OAT, 128'd0, OAT);
        wait_idle("idle_at");

        // trailer mismatch
        push(X, 128'd0, OC);
        send_frame(OC, {128{1'b1}}, OD);
        exp_drop++;
        wait_idle("idle_bad");
        chk("drop_bad", {136'd0, drop_cnt}, 144'(exp_drop));
        chk("key_unchanged", {16'd0, aes_key}, 144'd0);

        // transmitter busy holds off tx_send
        tx_busy = 1'b1;
        push(K, ASCII_HEX, OA);
        send_frame(OA, 128'd0, OA);
        sent = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 if (tx_send === 1'b1) sent = 1'b1;
        end
        chk("no_send_while_busy", {143'd0, sent}, 144'd0);
        @(negedge clk);
        tx_busy = 1'b0;
        @(posedge clk);
        #1 chk("send_after_busy", {143'd0, tx_send}, 144'd1);
        wait_idle("idle_A");

        push(X, 128'd0, OZ);
        send_frame(OZ, 128'h5a5a, OZ);
        exp_drop++;
        wait_idle("idle_Z");

        push(K, KEY2, OC);
        send_frame(OC, KEY2, OC);
        wait_idle("idle_C2");
        push(K, KEY2, OLA);
        send_frame(OLA, 128'd0, OLA);
        wait_idle("idle_a");
        push(K, PT, OLB);
        send_frame(OLB, 128'd0, OLB);
        wait_idle("idle_b");
        chk("drop_mid", {136'd0, drop_cnt}, 144'(exp_drop));

        // saturate drop_cnt while stuck in RESP
        tx_busy = 1'b1;
        push(K, ASCII_HEX, OA);
        send_frame(OA, 128'd0, OA);
        @(negedge clk);
        rx_valid = 1'b1;
        repeat (260) @(negedge clk);
        rx_valid = 1'b0;
        chk("drop_saturate", {136'd0, drop_cnt}, 144'd255);
        tx_busy = 1'b0;
        wait_idle("idle_sat");

        send_frame(OE, 128'd0, OE);
        wait_ld("aes_ld_hang");
`ifdef AES_SEQ_TIMEOUT_EN
        push(T, 128'd0, OE);
        wait_idle("idle_timeout");
        chk("drop_after_timeout", {136'd0, drop_cnt}, 144'd255);
        send_frame(OE, 128'd0, OE);
        wait_ld("aes_ld_rst");
        repeat (5) @(negedge clk);
`else
        repeat (100) @(negedge clk);
        chk("busy_hang", {143'd0, busy}, 144'd1);
`endif

        // reset in the middle of the cipher wait, then a late aes_done
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_tx_frame", tx_frame, 144'd0);
        chk("arst_key_text", {aes_key, 16'd0}, 144'd0);
        chk("arst_text", {16'd0, aes_text}, 144'd0);
        chk("arst_flags", {133'd0, tx_send, aes_ld, busy, drop_cnt}, 144'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        aes_done = 1'b1;
        aes_result = CT;
        @(negedge clk);
        aes_done = 1'b0;
        sent = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 if (tx_send === 1'b1 || busy === 1'b1) sent = 1'b1;
        end
        chk("late_done_ignored", {143'd0, sent}, 144'd0);
        chk("post_rst_outputs", {tx_frame[15:0], drop_cnt, aes_key}, 144'd0);

        push(K, 128'd0, OAT);
        send_frame(OAT, 128'd0, OAT);
        wait_idle("idle_post_rst");

        chk("all_responses_seen", 144'(exp_q.size()), 144'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
